// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one 12x12 shift-add multiplier between the EAE path (port 0)
// and the debug/console path (port 1); flushes the reset-less multiplier after reset or a hang.
module mul_share_ctrl #(
  parameter int TIMEOUT      = 31,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [11:0] a0,
  input  logic [11:0] a1,
  input  logic [11:0] b0,
  input  logic [11:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [23:0] result,
  output logic        busy,
  output logic        timeout_err,
  output logic        mul_start,
  output logic [11:0] mul_multiplier,
  output logic [11:0] mul_multiplicand,
  input  logic [23:0] mul_product,
  input  logic        mul_finished
);
  localparam int NREQ = 2;
  localparam int OPW  = 12;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic           id;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } grant_t;

  state_t                   r_state, w_state_nxt;
  logic [NREQ-1:0]          w_req;
  logic [NREQ-1:0][OPW-1:0] w_a, w_b;
  logic                     w_gid, w_grant_vld;
  grant_t                   w_grant;

  logic                     r_last_grant, r_gid, r_tmo_mark, r_timeout_err, r_mul_start;
  logic [NREQ-1:0]          r_ack;
  logic [23:0]              r_result;
  logic [OPW-1:0]           r_mul_a, r_mul_b;
  logic [TW-1:0]            r_wait_cnt;
  logic [FW-1:0]            r_flush_cnt;

  logic                     w_flush_done, w_wait_expired;
  logic                     w_start_nxt, w_capture, w_expire, w_busy;
  logic [NREQ-1:0]          w_ack_nxt;

  assign w_req = {req1, req0};
  assign w_a   = {a1, a0};
  assign w_b   = {b1, b0};

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign w_grant_vld = |w_req;
  assign w_gid       = (&w_req) ? ~r_last_grant : w_req[1];

  always_comb begin
    w_grant    = '0;
    w_grant.id = w_gid;
    w_grant.a  = w_a[w_gid];
    w_grant.b  = w_b[w_gid];
  end

  assign w_flush_done   = mul_finished || (r_flush_cnt == FW'(FLUSH_CYCLES - 1));
  assign w_wait_expired = (r_wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_FLUSH;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FLUSH: if (w_flush_done) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_grant_vld) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_BUSY;
      S_BUSY:  if (mul_finished || w_wait_expired) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = r_tmo_mark ? S_FLUSH : S_IDLE;
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  // Finish beats timeout when both land in the same cycle.
  always_comb begin
    w_start_nxt = (r_state == S_IDLE) && w_grant_vld;
    w_capture   = (r_state == S_BUSY) && mul_finished;
    w_expire    = (r_state == S_BUSY) && !mul_finished && w_wait_expired;
    w_busy      = r_state inside {S_ISSUE, S_BUSY, S_DONE};
    w_ack_nxt   = '0;
    if (w_capture || w_expire) w_ack_nxt[r_gid] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant  <= 1'b1;
      r_gid         <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_start   <= 1'b0;
      r_ack         <= '0;
      r_result      <= '0;
      r_timeout_err <= 1'b0;
      r_tmo_mark    <= 1'b0;
      r_wait_cnt    <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_mul_start <= w_start_nxt;
      r_ack       <= w_ack_nxt;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + FW'(1) : '0;
      r_wait_cnt  <= (r_state == S_BUSY)  ? r_wait_cnt + TW'(1)  : '0;
      if (w_start_nxt) begin
        r_mul_a      <= w_grant.a;
        r_mul_b      <= w_grant.b;
        r_gid        <= w_grant.id;
        r_last_grant <= w_grant.id;
      end
      if (w_capture) begin
        r_result   <= mul_product;
        r_tmo_mark <= 1'b0;
      end else if (w_expire) begin
        r_result      <= '0;
        r_timeout_err <= 1'b1;
        r_tmo_mark    <= 1'b1;
      end
    end
  end

  assign ack0             = r_ack[0];
  assign ack1             = r_ack[1];
  assign result           = r_result;
  assign busy             = w_busy;
  assign timeout_err      = r_timeout_err;
  assign mul_start        = r_mul_start;
  assign mul_multiplier   = r_mul_a;
  assign mul_multiplicand = r_mul_b;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: behavioural 13-cycle multiplier plus a transaction-level
// arbitration/timing reference model.
module tb_mul_share_ctrl;
  localparam int TIMEOUT      = 31;
  localparam int FLUSH_CYCLES = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [11:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic        ack0, ack1, busy, timeout_err, mul_start;
  logic [23:0] result;
  logic [11:0] mul_multiplier, mul_multiplicand;
  logic [23:0] mul_product;
  logic        mul_finished;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_last = 1;

  // Multiplier model: no reset, finished pulses 13 cycles after the start cycle.
  bit          hang = 1'b0;
  bit          force_fin = 1'b0;
  int          m_cnt = 0;
  logic        m_fin = 1'b0;
  logic [23:0] m_prod = '0;
  logic [11:0] m_a = '0, m_b = '0;

  mul_share_ctrl #(.TIMEOUT(TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .busy(busy), .timeout_err(timeout_err),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_finished(mul_finished)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    m_fin <= 1'b0;
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_fin  <= 1'b1;
        m_prod <= 24'(m_a) * 24'(m_b);
      end
    end else if (mul_start && !hang) begin
      m_cnt <= 12;
      m_a   <= mul_multiplier;
      m_b   <= mul_multiplicand;
    end
  end

  assign mul_product  = m_prod;
  assign mul_finished = m_fin | force_fin;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return (exp_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  // Collects what happens up to and including the first ack; judging is left to the caller.
  task automatic observe(input int budget, output int st_c, output int nst,
                         output logic [11:0] ma, output logic [11:0] mb,
                         output int ack_c, output int port, output logic [23:0] res,
                         output bit both, output int te_c, output bit te_low);
    st_c = -1; nst = 0; ma = 'x; mb = 'x; ack_c = -1; port = -1; res = 'x;
    both = 1'b0; te_c = -1; te_low = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (mul_start === 1'b1) begin
        if (st_c < 0) begin st_c = cyc; ma = mul_multiplier; mb = mul_multiplicand; end
        nst++;
      end
      if (timeout_err === 1'b1) begin
        if (te_c < 0) te_c = cyc;
      end else te_low = 1'b1;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        ack_c = cyc; port = (ack1 === 1'b1) ? 1 : 0; res = result;
        both = (ack0 === 1'b1) && (ack1 === 1'b1);
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rel, st_c, nst, ack_c, port, te_c;
    logic [11:0] ma, mb;
    logic [23:0] res, ep;
    bit both, te_low, nz;
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();
    total++;
    if ({ack0, ack1, busy, timeout_err, mul_start, result, mul_multiplier, mul_multiplicand} !== '0) begin
      bad++; $display("FAIL reset_outputs got result=%h busy=%b start=%b exp all zero", result, busy, mul_start);
    end
    a0 = 12'($urandom); b0 = 12'($urandom); ep = 24'(a0) * 24'(b0);
    req0 = 1'b1; reset_n = 1'b1; exp_last = 1; rel = cyc;
    nz = 1'b0;
    for (int k = 1; k <= FLUSH_CYCLES; k++) begin
      tick();
      if ({ack0, ack1, busy, timeout_err, mul_start, result, mul_multiplier, mul_multiplicand} !== '0) nz = 1'b1;
    end
    total++;
    if (nz) begin bad++; $display("FAIL flush_outputs got nonzero output during flush exp all zero"); end
    observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req0 = 1'b0; exp_last = 0;
    total++;
    if (st_c !== rel + FLUSH_CYCLES + 1) begin bad++; $display("FAIL flush_len start_cycle got=%0d exp=%0d", st_c - rel, FLUSH_CYCLES + 1); end
    total++;
    if (ack_c !== rel + FLUSH_CYCLES + 15 || port !== 0 || res !== ep) begin
      bad++; $display("FAIL reset_first_txn got ack@%0d port=%0d res=%h exp ack@%0d port=0 res=%h", ack_c - rel, port, res, FLUSH_CYCLES + 15, ep);
    end
  endtask

  task automatic test_single();
    int t0;
    bit e_start, e_ack0, e_ack1, e_busy, e_res, e_ops;
    tick();
    a0 = 12'o7777; b0 = 12'o7777; req0 = 1'b1; t0 = cyc;
    e_start = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_res = 0; e_ops = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (mul_start !== (k == 1)) e_start = 1;
      if (ack0 !== (k == 15)) e_ack0 = 1;
      if (ack1 !== 1'b0) e_ack1 = 1;
      if (busy !== (k >= 1 && k <= 15)) e_busy = 1;
      if (k == 1 && (mul_multiplier !== 12'o7777 || mul_multiplicand !== 12'o7777)) e_ops = 1;
      if (k >= 15 && result !== 24'hFFE001) e_res = 1;
      if (k == 15) req0 = 1'b0;
    end
    exp_last = 0;
    total++; if (e_start) begin bad++; $display("FAIL single_start got wrong mul_start pattern exp pulse at t0+1 only"); end
    total++; if (e_ack0) begin bad++; $display("FAIL single_ack0 got wrong ack0 pattern exp pulse at t0+15 only"); end
    total++; if (e_ack1) begin bad++; $display("FAIL single_ack1 got ack1 high exp never"); end
    total++; if (e_busy) begin bad++; $display("FAIL single_busy got wrong busy window exp t0+1..t0+15"); end
    total++; if (e_ops) begin bad++; $display("FAIL single_operands got %o/%o exp 7777/7777", mul_multiplier, mul_multiplicand); end
    total++; if (e_res) begin bad++; $display("FAIL single_result got=%h exp=ffe001 from ack onward", result); end
    tick();
  endtask

  task automatic test_round_robin();
    int t0, st_c, nst, ack_c, port, te_c, ep_port;
    logic [11:0] ma, mb;
    logic [23:0] res, ep;
    bit both, te_low;
    // Lone port-1 request first, so contention starts with port 0.
    a1 = 12'($urandom); b1 = 12'($urandom); ep = 24'(a1) * 24'(b1);
    req1 = 1'b1;
    ep_port = pick(1'b0, 1'b1); exp_last = ep_port;
    observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req1 = 1'b0;
    total++;
    if (port !== ep_port || res !== ep) begin bad++; $display("FAIL lone_req1 got port=%0d res=%h exp port=%0d res=%h", port, res, ep_port, ep); end
    tick();
    a0 = 12'd3; b0 = 12'd5; a1 = 12'd100; b1 = 12'd40;
    req0 = 1'b1; req1 = 1'b1; t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      ep_port = pick(1'b1, 1'b1); exp_last = ep_port;
      ep = (ep_port == 0) ? 24'd15 : 24'd4000;
      observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
      total++;
      if (port !== ep_port || res !== ep || both) begin
        bad++; $display("FAIL rr_grant%0d got port=%0d res=%0d both=%b exp port=%0d res=%0d", i, port, res, both, ep_port, ep);
      end
      total++;
      if (ack_c !== t0 + 15 + 16 * i || st_c !== t0 + 1 + 16 * i) begin
        bad++; $display("FAIL rr_timing%0d got start@%0d ack@%0d exp start@%0d ack@%0d", i, st_c - t0, ack_c - t0, 1 + 16 * i, 15 + 16 * i);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_random();
    int t0, st_c, nst, ack_c, port, te_c, ep_port, p;
    logic [11:0] ma, mb, ea, eb;
    logic [23:0] res, ep;
    bit both, te_low, r0, r1;
    for (int i = 0; i < 10; i++) begin
      tick();
      p = int'($urandom_range(1, 3)); r0 = p[0]; r1 = p[1];
      a0 = 12'($urandom); b0 = 12'($urandom); a1 = 12'($urandom); b1 = 12'($urandom);
      if (i == 0) begin a0 = 12'd0; b0 = 12'hFFF; end
      req0 = r0; req1 = r1; t0 = cyc;
      ep_port = pick(r0, r1); exp_last = ep_port;
      ea = (ep_port == 0) ? a0 : a1; eb = (ep_port == 0) ? b0 : b1;
      ep = 24'(ea) * 24'(eb);
      observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
      req0 = 1'b0; req1 = 1'b0;
      total++;
      if (port !== ep_port || res !== ep || both) begin
        bad++; $display("FAIL rand%0d_result got port=%0d res=%h exp port=%0d res=%h", i, port, res, ep_port, ep);
      end
      total++;
      if (st_c !== t0 + 1 || nst !== 1 || ack_c !== t0 + 15 || ma !== ea || mb !== eb) begin
        bad++; $display("FAIL rand%0d_issue got start@%0d n=%0d ack@%0d ops=%h/%h exp start@1 n=1 ack@15 ops=%h/%h", i, st_c - t0, nst, ack_c - t0, ma, mb, ea, eb);
      end
    end
  endtask

  task automatic test_timeout();
    int t0, f0, st_c, nst, ack_c, port, te_c;
    logic [11:0] ma, mb;
    logic [23:0] res, ep;
    bit both, te_low;
    tick();
    hang = 1'b1;
    a0 = 12'($urandom_range(1, 4095)); b0 = 12'($urandom_range(1, 4095));
    req0 = 1'b1; t0 = cyc; exp_last = pick(1'b1, 1'b0);
    observe(60, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req0 = 1'b0; hang = 1'b0;
    total++;
    if (ack_c !== t0 + 2 + TIMEOUT || port !== 0 || res !== 24'd0) begin
      bad++; $display("FAIL timeout_ack got ack@%0d port=%0d res=%h exp ack@%0d port=0 res=0", ack_c - t0, port, res, 2 + TIMEOUT);
    end
    total++;
    if (te_c !== t0 + 2 + TIMEOUT) begin bad++; $display("FAIL timeout_err_rise got @%0d exp @%0d", te_c - t0, 2 + TIMEOUT); end
    tick();
    f0 = cyc;
    total++;
    if (result !== 24'd0 || timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_hold got res=%h err=%b exp res=0 err=1", result, timeout_err); end
    a0 = 12'($urandom); b0 = 12'($urandom); ep = 24'(a0) * 24'(b0);
    req0 = 1'b1; exp_last = pick(1'b1, 1'b0);
    observe(60, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req0 = 1'b0;
    total++;
    if (st_c !== f0 + FLUSH_CYCLES + 1 || ack_c !== f0 + FLUSH_CYCLES + 15 || res !== ep) begin
      bad++; $display("FAIL post_timeout_txn got start@%0d ack@%0d res=%h exp start@%0d ack@%0d res=%h", st_c - f0, ack_c - f0, res, FLUSH_CYCLES + 1, FLUSH_CYCLES + 15, ep);
    end
    total++;
    if (te_low) begin bad++; $display("FAIL timeout_sticky got timeout_err low exp high until reset"); end
  endtask

  task automatic test_reset_mid();
    int t0, st_c, nst, ack_c, port, te_c;
    logic [11:0] ma, mb;
    logic [23:0] res, ep;
    bit both, te_low;
    tick();
    a1 = 12'($urandom); b1 = 12'($urandom); ep = 24'(a1) * 24'(b1);
    req1 = 1'b1; t0 = cyc;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({ack0, ack1, busy, timeout_err, mul_start, result, mul_multiplier, mul_multiplicand} !== '0) begin
      bad++; $display("FAIL async_clear got busy=%b err=%b res=%h ops=%h/%h exp all zero", busy, timeout_err, result, mul_multiplier, mul_multiplicand);
    end
    repeat (2) tick();
    reset_n = 1'b1; exp_last = 1;
    exp_last = pick(1'b0, 1'b1);
    observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req1 = 1'b0;
    total++;
    if (ack_c !== t0 + 30 || port !== 1 || res !== ep) begin
      bad++; $display("FAIL reset_mid_txn got ack@%0d port=%0d res=%h exp ack@30 port=1 res=%h", ack_c - t0, port, res, ep);
    end
    total++;
    if (st_c !== t0 + 16 || te_c !== -1) begin
      bad++; $display("FAIL reset_mid_flush got start@%0d err_rise=%0d exp start@16 no err", st_c - t0, te_c);
    end
  endtask

  task automatic test_flush_early();
    int rel, st_c, nst, ack_c, port, te_c;
    logic [11:0] ma, mb;
    logic [23:0] res, ep;
    bit both, te_low;
    reset_n = 1'b0;
    repeat (2) tick();
    a0 = 12'($urandom); b0 = 12'($urandom); ep = 24'(a0) * 24'(b0);
    req0 = 1'b1; reset_n = 1'b1; rel = cyc; exp_last = 1;
    exp_last = pick(1'b1, 1'b0);
    repeat (3) tick();
    force_fin = 1'b1;
    tick();
    force_fin = 1'b0;
    observe(40, st_c, nst, ma, mb, ack_c, port, res, both, te_c, te_low);
    req0 = 1'b0;
    total++;
    if (st_c !== rel + 5) begin bad++; $display("FAIL flush_early_exit got start@%0d exp start@5", st_c - rel); end
    total++;
    if (ack_c !== rel + 19 || port !== 0 || res !== ep) begin
      bad++; $display("FAIL flush_early_txn got ack@%0d port=%0d res=%h exp ack@19 port=0 res=%h", ack_c - rel, port, res, ep);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid();
    test_flush_early();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
